// File: rtl/full_adder_latch_pkg.sv
// Shared constants and a reference sum for the registered adder.
package full_adder_latch_pkg;

   localparam int DEFAULT_WIDTH = 4;

   function automatic logic [31:0] sum_mod(
      input logic [31:0] a,
      input logic [31:0] b,
      input int          width
   );
      logic [32:0] full;
      logic [32:0] mask;
      full = {1'b0, a} + {1'b0, b};
      mask = (33'd1 << width) - 33'd1;
      return 32'(full & mask);
   endfunction

endpackage

// File: rtl/full_adder_latch_cell.sv
// One-bit full adder; the building block of the ripple chain.
module full_adder_cell (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/full_adder_latch.sv
// Ripple-carry adder feeding an enable-gated result register.
module full_adder_latch
   import full_adder_latch_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             en,
   output logic [WIDTH-1:0] c
);

   logic [WIDTH:0]   w_carry;
   logic [WIDTH-1:0] w_sum;
   logic             w_unused_cout;
   logic [WIDTH-1:0] r_c;

   assign w_carry[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_chain
      full_adder_cell u_cell (
         .x  (a[i]),
         .y  (b[i]),
         .ci (w_carry[i]),
         .s  (w_sum[i]),
         .co (w_carry[i+1])
      );
   end

   // Result is modular; the final carry is intentionally dropped.
   assign w_unused_cout = w_carry[WIDTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_c <= '0;
      end else if (en) begin
         r_c <= w_sum;
      end
   end

   assign c = r_c;

endmodule

// File: tb/tb_full_adder_latch.sv
// Directed and random checks of full_adder_latch at widths 4, 8 and 1.
module tb_full_adder_latch;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [3:0] a4, b4, c4;
   logic [7:0] a8, b8, c8;
   logic [0:0] a1, b1, c1;

   int checks = 0;
   int errors = 0;
   bit cmp_on = 1'b0;

   int exp4 = 0;
   int exp8 = 0;
   int exp1 = 0;

   always #5 clk = ~clk;

   full_adder_latch #(.WIDTH(4)) u_dut4 (
      .clk (clk), .rst (rst), .a (a4), .b (b4), .en (en), .c (c4)
   );

   full_adder_latch #(.WIDTH(8)) u_dut8 (
      .clk (clk), .rst (rst), .a (a8), .b (b8), .en (en), .c (c8)
   );

   full_adder_latch #(.WIDTH(1)) u_dut1 (
      .clk (clk), .rst (rst), .a (a1), .b (b1), .en (en), .c (c1)
   );

   // Model: sampled modular sums, cleared whenever reset is low.
   always @(negedge rst) begin
      exp4 = 0;
      exp8 = 0;
      exp1 = 0;
   end

   always @(posedge clk) begin
      if (rst !== 1'b1) begin
         exp4 = 0;
         exp8 = 0;
         exp1 = 0;
      end else if (en === 1'b1) begin
         exp4 = (int'(a4) + int'(b4)) % 16;
         exp8 = (int'(a8) + int'(b8)) % 256;
         exp1 = (int'(a1) + int'(b1)) % 2;
      end
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("model_c4", 32'(c4), 32'(exp4));
         chk("model_c8", 32'(c8), 32'(exp8));
         chk("model_c1", 32'(c1), 32'(exp1));
      end
   end

   task automatic step(input logic [3:0] va, input logic [3:0] vb,
                       input logic ve);
      a4 = va;
      b4 = vb;
      a8 = {4'h0, va};
      b8 = {4'h0, vb};
      a1 = va[0];
      b1 = vb[0];
      en = ve;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] hold_a [4] = '{4'h0, 4'h1, 4'h2, 4'h3};
   logic [3:0] hold_b [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
   logic [3:0] ovf_b  [3] = '{4'h1, 4'hF, 4'h8};
   logic [3:0] ovf_c  [3] = '{4'h0, 4'hE, 4'h7};
   logic [3:0] sum_c  [4] = '{4'hA, 4'hC, 4'hE, 4'h0};

   initial begin
      rst = 1'b0;
      en  = 1'b0;
      a4 = '0; b4 = '0;
      a8 = '0; b8 = '0;
      a1 = '0; b1 = '0;
      #1;
      cmp_on = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_c", 32'(c4), 32'h0);

      step(4'h5, 4'h5, 1'b1);
      chk("reset_ignores_en", 32'(c4), 32'h0);

      #2 rst = 1'b1;

      for (int i = 0; i < 4; i++) begin
         step(hold_a[i], hold_b[i], 1'b1);
         chk("enabled_sum", 32'(c4), 32'(sum_c[i]));
      end

      for (int i = 0; i < 4; i++) begin
         step(hold_a[i], hold_b[i], 1'b0);
         chk("hold", 32'(c4), 32'h0);
      end

      step(4'h2, 4'h3, 1'b1);
      chk("after_hold", 32'(c4), 32'h5);

      step(4'h7, 4'h7, 1'b1);
      chk("pre_async", 32'(c4), 32'hE);

      en = 1'b0;
      #2 rst = 1'b0;
      #1 chk("async_clear", 32'(c4), 32'h0);
      a4 = 4'h7; b4 = 4'h1;
      a8 = 8'h07; b8 = 8'h01;
      a1 = 1'b1;  b1 = 1'b1;
      en = 1'b1;
      #2 rst = 1'b1;
      @(posedge clk);
      #1 chk("first_capture", 32'(c4), 32'h8);

      for (int i = 0; i < 3; i++) begin
         step(4'hF, ovf_b[i], 1'b1);
         chk("overflow", 32'(c4), 32'(ovf_c[i]));
      end

      a8 = 8'hFF; b8 = 8'h02;
      a1 = 1'b1;  b1 = 1'b1;
      en = 1'b1;
      @(posedge clk);
      #1;
      chk("width8_wrap", 32'(c8), 32'h01);
      chk("width1_wrap", 32'(c1), 32'h0);

      for (int n = 0; n < 1000; n++) begin
         a4 = 4'($urandom);
         b4 = 4'($urandom);
         a8 = 8'($urandom);
         b8 = 8'($urandom);
         a1 = 1'($urandom);
         b1 = 1'($urandom);
         en = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         if (en)
            chk("rand_sum_mod", 32'(c4),
                full_adder_latch_pkg::sum_mod(32'(a4), 32'(b4), 4));
      end

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
